// File: rtl/wshb_frame_reader_pkg.sv
// frame_reader_pkg: types and helpers shared by the frame reader files.
//   state_t      : read-burst FSM states (IDLE, BURST, GAP)
//   fifo_word_t  : one buffered pixel, {start-of-frame flag, 24-bit RGB}
//   frame_pixels : number of pixels in one frame
package frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        sof;
    logic [23:0] rgb;
  } fifo_word_t;

  function automatic int unsigned frame_pixels(input int unsigned hdisp,
                                               input int unsigned vdisp);
    return hdisp * vdisp;
  endfunction

endpackage

// File: rtl/wshb_frame_reader_if.sv
// wshb_if: Wishbone classic bus (32-bit data, byte addressing).
//   master modport : drives cyc/stb/we/sel/adr/dat_ms, receives dat_sm/ack
//   slave modport  : the reverse direction
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_ms,
                  input  dat_sm, ack);
  modport slave  (input  cyc, stb, we, sel, adr, dat_ms,
                  output dat_sm, ack);
endinterface

// File: rtl/wshb_frame_reader_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push/wdata : write port; an entry is visible at rdata one cycle later
//   pop        : removes the head entry (ignored while empty)
//   rdata      : head entry, valid whenever empty=0
//   empty/full/count : occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // The upstream free-space check must make this impossible.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
                                        !(push && full));

endmodule

// File: rtl/wshb_frame_reader.sv
// wshb_frame_reader: Wishbone read master streaming a framebuffer out of
// SDRAM as a valid/ready pixel stream.
//   clk, rst_n      : single clock, asynchronous active-low reset
//   wshb            : Wishbone master port (read only, bounded bursts)
//   pix_data/pix_sof/pix_valid/pix_ready : show-ahead pixel stream
//   underflow_cnt   : saturating count of cycles with pix_ready=1 and no
//                     pixel available; only built when the macro
//                     FRAME_READER_UNDERFLOW_CNT_EN is defined, else 0.
module wshb_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  wshb_if.master      wshb,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] underflow_cnt
);
  localparam int unsigned FRAME_PIX = frame_pixels(HDISP, VDISP);
  localparam int unsigned IDX_W     = $clog2(FRAME_PIX);
  localparam int unsigned BEAT_W    = $clog2(BURST_LEN);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WORD_W    = $bits(fifo_word_t);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_PIX - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  SPACE_LIM = CNT_W'(FIFO_DEPTH - BURST_LEN);

  state_t              state_q, state_d;
  logic [31:0]         adr_q, adr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  fifo_word_t          wword, head;
  logic                space_ok;
  logic                unused_bits;

  assign space_ok    = (fifo_count <= SPACE_LIM);
  assign unused_bits = ^{wshb.dat_sm[31:24], fifo_full};

  assign wword.sof = (idx_q == '0);
  assign wword.rgb = wshb.dat_sm[23:0];

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (space_ok) state_d = BURST;
      end
      BURST: begin
        if (wshb.ack) begin
          fifo_push = 1'b1;
          beat_d    = beat_q + BEAT_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            adr_d = BASE_ADDR;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            adr_d = adr_q + 32'd4;
          end
          // Bursts end at BURST_LEN words or at the frame's last pixel.
          if (beat_q == LAST_BEAT || idx_q == LAST_IDX) begin
            state_d = GAP;
            beat_d  = '0;
          end
        end
      end
      GAP: begin
        // The IDLE space check is folded in here so cyc is low for exactly
        // one cycle when the FIFO can already take another burst.
        state_d = space_ok ? BURST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= BASE_ADDR;
      idx_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
    end
  end

  // cyc/stb come straight from the state flop, so an asynchronous reset
  // drops them at once.
  assign wshb.cyc    = (state_q == BURST);
  assign wshb.stb    = (state_q == BURST);
  assign wshb.we     = 1'b0;
  assign wshb.sel    = 4'hF;
  assign wshb.adr    = adr_q;
  assign wshb.dat_ms = 32'h0;

  assign pix_valid = !fifo_empty;
  assign fifo_pop  = pix_valid && pix_ready;
  assign pix_data  = head.rgb;
  assign pix_sof   = pix_valid && head.sof;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wword),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`ifdef FRAME_READER_UNDERFLOW_CNT_EN
  logic [15:0] uf_q, uf_d;

  always_comb begin
    uf_d = uf_q;
    if (pix_ready && fifo_empty && uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uf_q <= '0;
    else        uf_q <= uf_d;
  end

  assign underflow_cnt = uf_q;
`else
  assign underflow_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Bench for wshb_frame_reader (HDISP=4, VDISP=2, FIFO_DEPTH=8, BURST_LEN=4,
// BASE_ADDR=0x100). The bench acts as the Wishbone slave over a small
// random memory; a negedge monitor keeps a queue of expected pixels and the
// expected frame position, and checks bus and stream behaviour every cycle.
module tb_wshb_frame_reader;
  localparam int          NPIX  = 8;
  localparam int          DEPTH = 8;
  localparam int          BL    = 4;
  localparam logic [31:0] BASE  = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] pix_data;
  logic        pix_sof, pix_valid;
  logic        pix_ready = 1'b0;
  logic [15:0] underflow_cnt;
  logic        ack_want = 1'b0;
  int          ack_mode = 0;
  int          rdy_mode = 0;

  logic [31:0] mem [NPIX];
  logic [31:0] off;

  wshb_if bus ();

  assign off        = bus.adr - BASE;
  assign bus.dat_sm = mem[off[4:2]];
  assign bus.ack    = ack_want & bus.cyc;

  wshb_frame_reader #(
    .HDISP (4), .VDISP (2), .BASE_ADDR (BASE), .FIFO_DEPTH (DEPTH), .BURST_LEN (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wshb          (bus),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [24:0] q[$];
  int exp_idx = 0, exp_uf = 0, acks_in_cyc = 0, ack_total = 0, pop_cnt = 0;
  bit frame_end = 0, prev_wait = 0;
  logic [31:0] prev_adr = '0;

  // Slave / consumer driver: applies the requested modes 2 time units
  // after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ack_want  = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 3) != 0);
      pix_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    end
  end

  // Monitor: at each falling edge, compare DUT outputs with the model and
  // then apply the transfers that the coming rising edge will perform.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_cyc", bus.cyc, 1'b0);
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_uf", underflow_cnt, 16'h0);
        q.delete();
        exp_idx = 0; exp_uf = 0; acks_in_cyc = 0; frame_end = 0; prev_wait = 0;
      end else begin
        chk("stb_eq_cyc", bus.stb, bus.cyc);
        chk("valid", pix_valid, q.size() != 0);
        if (pix_valid && q.size() != 0) chk("head", {pix_sof, pix_data}, q[0]);
        chk("underflow", underflow_cnt, exp_uf);
        if (prev_wait && bus.cyc) chk("adr_stable", bus.adr, prev_adr);
        prev_wait = bus.stb && !bus.ack;
        prev_adr  = bus.adr;
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
        if (pix_ready && q.size() == 0 && exp_uf < 65535) exp_uf++;
`endif
        if (pix_valid && pix_ready && q.size() != 0) begin
          void'(q.pop_front());
          pop_cnt++;
        end
        if (bus.cyc && bus.ack) begin
          chk("adr", bus.adr, BASE + 32'(4 * exp_idx));
          chk("burst_len", acks_in_cyc < BL, 1'b1);
          chk("frame_cross", frame_end, 1'b0);
          q.push_back({exp_idx == 0, mem[exp_idx][23:0]});
          chk("no_overflow", q.size() <= DEPTH, 1'b1);
          acks_in_cyc++;
          if (exp_idx == NPIX - 1) frame_end = 1;
          exp_idx = (exp_idx + 1) % NPIX;
          ack_total++;
        end else if (!bus.cyc) begin
          acks_in_cyc = 0;
          frame_end = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0;
    logic [11:0] v;
    for (int i = 0; i < NPIX; i++) mem[i] = $urandom;

    // 1: ack withheld -> burst request held at BASE
    ack_mode = 0; rdy_mode = 0;
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    chk("t1_cyc", bus.cyc, 1'b1);
    chk("t1_adr", bus.adr, 32'h100);
    chk("t1_we", bus.we, 1'b0);
    chk("t1_sel", bus.sel, 4'hF);
    chk("t1_dat_ms", bus.dat_ms, 32'h0);
    chk("t1_valid", pix_valid, 1'b0);

    // 2: ack every cycle, no consumer -> two bursts, one-cycle gap, then stop
    ack_mode = 1;
    do_reset();
    a0 = ack_total;
    v = '0;
    repeat (12) begin
      @(negedge clk);
      v = {v[10:0], bus.cyc};
    end
    chk("t2_cyc_pattern", v, 12'h7BC);
    repeat (5) @(negedge clk);
    chk("t2_cyc_idle", bus.cyc, 1'b0);
    chk("t2_valid", pix_valid, 1'b1);
    chk("t2_acks", ack_total - a0, 8);

    // 3: drain four -> refill burst wraps to BASE
    @(posedge clk); #1;
    p0 = pop_cnt;
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    #1 rdy_mode = 0;
    repeat (15) @(posedge clk);
    #1;
    chk("t3_pops", pop_cnt - p0, 4);
    chk("t3_acks", ack_total - a0, 12);
    chk("t3_head_data", pix_data, mem[4][23:0]);
    chk("t3_head_sof", pix_sof, 1'b0);
    ack_mode = 0; rdy_mode = 1;
    repeat (12) @(posedge clk);
    #1 chk("t3_drained", pix_valid, 1'b0);

    // 4: random traffic, then three frames of continuous flow
    ack_mode = 2; rdy_mode = 2;
    repeat (400) @(posedge clk);
    #1 ack_mode = 1; rdy_mode = 1;
    p0 = pop_cnt;
    for (int i = 0; i < 300 && (pop_cnt - p0) < 3 * NPIX; i++) @(posedge clk);
    chk("t4_three_frames", (pop_cnt - p0) >= 3 * NPIX, 1'b1);

    // 5: reset mid-burst after two acks
    ack_mode = 1; rdy_mode = 0;
    do_reset();
    a0 = ack_total;
    for (int i = 0; i < 50 && (ack_total - a0) < 2; i++) @(posedge clk);
    chk("t5_two_acks", ack_total - a0, 2);
    #1 chk("t5_cyc_before", bus.cyc, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_cyc_drop", bus.cyc, 1'b0);
    chk("t5_fifo_empty", pix_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20 && !bus.cyc; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_restart_cyc", bus.cyc, 1'b1);
    chk("t5_restart_adr", bus.adr, 32'h100);

    // 6: consumer ready, no data for 20 cycles
    ack_mode = 0; rdy_mode = 1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
    chk("t6_underflow", underflow_cnt, 16'd20);
`else
    chk("t6_underflow", underflow_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
